// File: rtl/math_adder_bk_multiword_seq_pkg.sv
// Shared types for the byte-serial wide adder: FSM states, chunk width, counter sizing.
package math_adder_bk_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} adder_seq_state_t;

  localparam int CHUNK_W = 8;

  // Width of a counter that indexes beats 0..BEATS-1 (at least one bit).
  function automatic int beat_cnt_w(input int width);
    int beats;
    beats = width / CHUNK_W;
    return (beats > 2) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/math_adder_bk_multiword_seq_bk8.sv
// 8-bit Brent-Kung prefix adder with carry-in folded into the bit-0 generate.
// Purely combinational.
module math_adder_brent_kung_008 #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  logic [N-1:0] g, p;
  logic g0c, g10, g32, p32, g54, p54, g76, p76;
  logic g30, g74, p74, g70, g50, g20, g40, g60;

  assign g   = a & b;
  assign p   = a ^ b;
  assign g0c = g[0] | (p[0] & ci);

  // Up-sweep
  assign g10 = g[1] | (p[1] & g0c);
  assign g32 = g[3] | (p[3] & g[2]);
  assign p32 = p[3] & p[2];
  assign g54 = g[5] | (p[5] & g[4]);
  assign p54 = p[5] & p[4];
  assign g76 = g[7] | (p[7] & g[6]);
  assign p76 = p[7] & p[6];
  assign g30 = g32 | (p32 & g10);
  assign g74 = g76 | (p76 & g54);
  assign p74 = p76 & p54;
  assign g70 = g74 | (p74 & g30);

  // Down-sweep fills the remaining prefixes
  assign g50 = g54 | (p54 & g30);
  assign g20 = g[2] | (p[2] & g10);
  assign g40 = g[4] | (p[4] & g30);
  assign g60 = g[6] | (p[6] & g50);

  assign s  = p ^ {g60, g50, g40, g30, g20, g10, g0c, ci};
  assign co = g70;

endmodule

// File: rtl/math_adder_bk_multiword_seq.sv
// Byte-serial WIDTH-bit adder over one 8-bit BK adder; result after BEATS beats, held until i_ready.
// Optional MATH_ADDER_BK_SEQ_OVERFLOW_EN adds registered signed-overflow output o_ovf.
module math_adder_bk_multiword_seq
  import math_adder_bk_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
`ifdef MATH_ADDER_BK_SEQ_OVERFLOW_EN
  output logic             o_ovf,
`endif
  output logic             o_busy
);

  localparam int BEATS = WIDTH / CHUNK_W;
  localparam int CNT_W = beat_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  adder_seq_state_t   state_q, state_d;
  logic [CNT_W-1:0]   beat_q;
  logic [WIDTH-1:0]   a_sr, b_sr, res_sr;
  logic               carry_q;
  logic [CHUNK_W-1:0] byte_sum;
  logic               byte_cout;
  logic               last_beat;

  assign last_beat = (beat_q == LAST_BEAT);

  math_adder_brent_kung_008 #(.N(CHUNK_W)) u_bk8 (
    .a  (a_sr[CHUNK_W-1:0]),
    .b  (b_sr[CHUNK_W-1:0]),
    .ci (carry_q),
    .s  (byte_sum),
    .co (byte_cout)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_busy  = 1'b0;
    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_d = RUN;
      end
      RUN: begin
        o_busy = 1'b1;
        if (last_beat) state_d = DONE;
      end
      DONE: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte sums enter at the MSB end so after BEATS shifts byte 0 lands at the LSB.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry_q <= 1'b0;
      beat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_valid) begin
          a_sr    <= i_a;
          b_sr    <= i_b;
          carry_q <= i_c;
          beat_q  <= '0;
        end
        RUN: begin
          a_sr    <= a_sr >> CHUNK_W;
          b_sr    <= b_sr >> CHUNK_W;
          res_sr  <= {byte_sum, res_sr[WIDTH-1:CHUNK_W]};
          carry_q <= byte_cout;
          beat_q  <= last_beat ? '0 : beat_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_sum   = res_sr;
  assign o_carry = carry_q;

`ifdef MATH_ADDER_BK_SEQ_OVERFLOW_EN
  logic a_msb, b_msb, ovf_q;

  // The final beat's byte_sum[7] is the result MSB.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else if (state_q == IDLE && i_valid) begin
      a_msb <= i_a[WIDTH-1];
      b_msb <= i_b[WIDTH-1];
    end else if (state_q == RUN && last_beat) begin
      ovf_q <= (a_msb == b_msb) && (byte_sum[CHUNK_W-1] != a_msb);
    end
  end

  assign o_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_math_adder_bk_multiword_seq.sv
// Scoreboard bench for the byte-serial wide adder: directed vectors, back-pressure, async reset, random ready.
module tb_math_adder_bk_multiword_seq;

  localparam int WIDTH = 32;
  localparam int BEATS = WIDTH / 8;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_valid = 1'b0;
  logic             i_ready = 1'b1;
  logic             i_c = 1'b0;
  logic [WIDTH-1:0] i_a = '0;
  logic [WIDTH-1:0] i_b = '0;
  logic             o_ready, o_valid, o_carry, o_busy;
  logic [WIDTH-1:0] o_sum;
`ifdef MATH_ADDER_BK_SEQ_OVERFLOW_EN
  logic             o_ovf;
`endif

  math_adder_bk_multiword_seq #(.WIDTH(WIDTH)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_c     (i_c),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sum   (o_sum),
    .o_carry (o_carry),
`ifdef MATH_ADDER_BK_SEQ_OVERFLOW_EN
    .o_ovf   (o_ovf),
`endif
    .o_busy  (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rdy_mode = 0;      // 0: always ready, 1: stalled, 2: random
  int last_acc = -1;
  logic [WIDTH+1:0] exp_q[$];   // {ovf, carry, sum}
  int acc_q[$];

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
  } vec_t;

  vec_t vecs[7] = '{
    '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0},
    '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0},
    '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1},
    '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1},
    '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0},
    '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0},
    '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0}
  };

  always @(posedge i_clk) cyc++;

  always @(posedge i_clk) begin
    #1;
    case (rdy_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = 1'b0;
      default: i_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: latency on each rising o_valid, stability under stall, result on handshake.
  logic             prev_vld = 1'b0;
  logic [WIDTH:0]   held = '0;
  logic [WIDTH+1:0] e;
  always @(negedge i_clk) begin
    if (i_rst) begin
      prev_vld = 1'b0;
    end else begin
      if (o_valid && !prev_vld) begin
        if (acc_q.size() == 0) check("spurious_valid", 1, 0);
        else check("latency", cyc - acc_q.pop_front(), BEATS);
      end
      if (o_valid && prev_vld) check("hold_stable", {o_carry, o_sum}, held);
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) check("spurious_result", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("sum", o_sum, e[WIDTH-1:0]);
          check("carry", o_carry, e[WIDTH]);
`ifdef MATH_ADDER_BK_SEQ_OVERFLOW_EN
          check("ovf", o_ovf, e[WIDTH+1]);
`endif
        end
      end
      held = {o_carry, o_sum};
      prev_vld = o_valid;
    end
  end

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                       input logic [WIDTH-1:0] sum, input logic carry, input logic ovf);
    logic got;
    got = 1'b0;
    @(negedge i_clk);
    i_valid = 1'b1; i_a = a; i_b = b; i_c = c;
    for (int t = 0; t < 300; t++) begin
      got = o_ready;
      @(posedge i_clk);
      #1;
      if (got) break;
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    if (!got) check("accept_timeout", 0, 1);
    else begin
      exp_q.push_back({ovf, carry, sum});
      acc_q.push_back(cyc);
      if (last_acc >= 0) check("ii_min", 64'(cyc - last_acc >= BEATS + 2), 1);
      last_acc = cyc;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(negedge i_clk);
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] ra, rb, rs;
    logic             rc, rco, rov;

    #3;
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_sum", o_sum, 0);
    check("rst_carry", o_carry, 0);
    @(negedge i_clk);
    i_rst = 1'b0;

    foreach (vecs[i])
      issue(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sum, vecs[i].carry, vecs[i].ovf);
    drain();

    // Back-pressure: stalled result must hold and block a new request.
    rdy_mode = 1;
    issue(32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0);
    for (int t = 0; t < 50 && !o_valid; t++) @(negedge i_clk);
    check("bp_valid_seen", o_valid, 1);
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1; i_a = 32'h00000003; i_b = 32'h00000004; i_c = 1'b0;
      check("bp_ready_low", o_ready, 0);
      check("bp_valid_hold", o_valid, 1);
      @(negedge i_clk);
    end
    rdy_mode = 0;
    issue(32'h00000003, 32'h00000004, 1'b0, 32'h00000007, 1'b0, 1'b0);
    drain();

    // Async reset during beat 2 discards the operation.
    issue(32'h01020304, 32'h05060708, 1'b1, 32'h06080A0D, 1'b0, 1'b0);
    @(posedge i_clk);
    #3;
    i_rst = 1'b1;
    #1;
    check("arst_valid", o_valid, 0);
    check("arst_busy", o_busy, 0);
    check("arst_ready", o_ready, 1);
    check("arst_sum", o_sum, 0);
    exp_q.delete();
    acc_q.delete();
    last_acc = -1;
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (8) @(negedge i_clk);
    issue(32'h00000005, 32'h00000007, 1'b0, 32'h0000000C, 1'b0, 1'b0);
    drain();

    // Random operands with random downstream stalls.
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      {rco, rs} = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
      rov = (ra[WIDTH-1] == rb[WIDTH-1]) && (rs[WIDTH-1] != ra[WIDTH-1]);
      issue(ra, rb, rc, rs, rco, rov);
    end
    drain();
    rdy_mode = 0;
    repeat (4) @(negedge i_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
